// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default
// frame geometry.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// The reset value is chosen so that an idle line reads as inactive.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled start/data/parity/stop framing with
// a one-cycle valid strobe and sticky per-frame error flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);

    logic rxd_s;

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [CW-1:0]        cnt_inc;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rxd_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (RxD),
        .q_o   (rxd_s)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        if (state_q != IDLE && !Rx_EN) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else if (sample_ENABLE) begin
            unique case (state_q)
                IDLE: begin
                    if (Rx_EN && !rxd_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                // Detecting tick counts as the first half-bit tick.
                START: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_HALF) begin
                        cnt_d = '0;
                        if (!rxd_s) begin
                            state_d = DATA;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_MAX) begin
                            bit_d   = '0;
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d     = '0;
                        par_err_d = ((^shift_q) ^ rxd_s) != PARITY_ODD;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        ferr_d  = !rxd_s;
                        perr_d  = par_err_q;
                        state_d = IDLE;
                        if (rxd_s && !par_err_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;

endmodule
